seq_detector_param: RTL and testbench
=====================================

// Module: seq_detector_param
// PURPOSE
//  Parametrised serial pattern recogniser, successor to the fixed "011" detector.
//  Samples a 1-bit stream only on cycles qualified by valid, matches a LEN-bit PATTERN.
//  Selectable overlapping or non-overlapping detection.
//  On each match: holds out high for HOLD clocks, retriggerable; pulses match for one
//  clock; keeps a saturating hit count. Sits between a serial input front-end and
//  control logic that needs a stretched "pattern seen" flag.
// PARAMETERS
//  LEN      3       pattern length in bits, 2..16
//  PATTERN  3'b011  target pattern; PATTERN[LEN-1] is the first bit received
//  HOLD     4       clocks out stays high after a match, 1..255
//  OVERLAP  1       1: history kept after match; 0: history discarded after match
//  CNT_W    8       width of hits counter
// PORTS
//  clock    in   1      system clock, posedge
//  _reset   in   1      synchronous reset, active low
//  in       in   1      serial data bit
//  valid    in   1      in is sampled only when 1
//  out      out  1      stretched detection flag, registered
//  match    out  1      one-clock pulse per detected pattern, registered
//  hits     out  CNT_W  number of matches since reset, saturates at all-ones
// BEHAVIOUR
//  - Reset: _reset sampled at posedge clock, active low, synchronous.
//    Edge with _reset==0 sets out=0, match=0, hits=0, history=0, fill=0, state=HUNT,
//    hold counter=0. Reset wins over every other event on that edge.
//  - History: LEN-bit shift register plus fill counter 0..LEN.
//    On a valid edge: hist<={hist[LEN-2:0],in}, and fill increments, saturating at LEN.
//    valid==0: history and fill unchanged; the hold timer still runs.
//  - Match condition, evaluated on a valid edge: (fill>=LEN-1) && {hist[LEN-2:0],in}==PATTERN.
//    No match is possible before LEN valid bits have been received since reset.
//  - Latency: out and match rise on the same edge that samples the last pattern bit.
//    That is zero extra clocks, as in the fixed detector.
//  - On match: match<=1 for exactly that one clock; hits<=hits+1 unless all-ones.
//    If OVERLAP==0, fill<=0 on the same edge, so the next match needs LEN fresh bits.
//  - FSM states: HUNT (out=0), STRETCH (out=1).
//    HUNT  -> STRETCH on match; cnt<=HOLD-1.
//    STRETCH, match on this edge -> stay; cnt<=HOLD-1 (retrigger, window restarts).
//    STRETCH, no match, cnt!=0   -> stay; cnt<=cnt-1.
//    STRETCH, no match, cnt==0   -> HUNT; out<=0.
//    Result: out high exactly HOLD clocks after the last match edge.
//    Detection is never blocked while STRETCH is active.
//  - match==0 on every edge without a match; match never stays high 2 clocks unless
//    matches occur on consecutive valid edges.
//  - Widths: cnt is 8 bits; fill is $clog2(LEN+1) bits; hits wraps never (saturates).
//  - Illegal parameters (LEN<2, HOLD<1): behaviour undefined; elaboration-time check
//    via $display/$finish.
// STRUCTURE
//  - seq_detector_defs.vh: state encodings ST_HUNT=1'b0, ST_STRETCH=1'b1,
//    hold-counter width HOLD_W=8; included by RTL and testbench.
//  - Sub-module hold_timer: loadable down-counter.
//    Inputs: load, load_val.
//    Outputs: zero, i.e. the cnt logic of the STRETCH state.
//  - Top module keeps the history register, fill counter, comparator, FSM and
//    hits counter.
// TESTING
//  1 Reset: _reset=0 for 2 clocks with in/valid toggling -> out=0, match=0, hits=0.
//  2 Defaults, valid=1, in=0,1,1 -> out=1 and match=1 at edge 3; out high edges 3-6,
//    low at edge 7; hits=1.
//  3 Retrigger, defaults: in=0,1,1,0,1,1 -> matches at edges 3 and 6; out continuously
//    high edges 3-9, low at edge 10; hits=2.
//  4 LEN=4, PATTERN=4'b0101, in=0,1,0,1,0,1 -> OVERLAP=1 gives matches at edges 4 and 6
//    (hits=2); OVERLAP=0 gives a match at edge 4 only (hits=1).
//  5 valid gaps: in=0 (valid), then in=1 with valid=0 for 3 clocks, then 1,1 (valid)
//    -> exactly one match, on the last valid edge.
//  6 Reset mid-operation: after 0,1,1 match, _reset=0 on 2nd hold clock -> out=0 at
//    that edge, hits=0. Then in=1,1 -> no match (history cleared).
//  7 Saturation: CNT_W=2, 5 non-overlapping matches -> hits sticks at 3.

Source files
------------

// File: rtl/seq_detector_param_pkg.sv
// -----------------------------------------------------------------------------
// seq_detector_param_pkg
// Shared definitions for the parametrised serial pattern detector:
//   - state_e  : FSM state encoding (HUNT = out low, STRETCH = out high)
//   - HOLD_W   : width of the stretch hold counter
//   - hold_reload() : value loaded into the hold counter on every match
// No ports (package).
// -----------------------------------------------------------------------------
package seq_detector_param_pkg;

    typedef enum logic [0:0] {
        ST_HUNT    = 1'b0,
        ST_STRETCH = 1'b1
    } state_e;

    localparam int HOLD_W = 8;

    // The match edge itself is the first high clock, so the counter only has
    // to cover the remaining HOLD-1 clocks.
    function automatic logic [HOLD_W-1:0] hold_reload(input int hold);
        return HOLD_W'(hold - 1);
    endfunction

endpackage

// File: rtl/seq_detector_param_hold_timer.sv
// -----------------------------------------------------------------------------
// seq_detector_param_hold_timer
// Loadable down-counter that times the STRETCH window of the detector.
// Loads load_val_i when load_i is high, otherwise counts down to zero and
// stays there.
// Ports:
//   clk_i       in   1       system clock, posedge
//   rst_ni      in   1       synchronous reset, active low (clears counter)
//   load_i      in   1       load request (a match was seen on this edge)
//   load_val_i  in   HOLD_W  value to load
//   zero_o      out  1       counter is at zero
// -----------------------------------------------------------------------------
module seq_detector_param_hold_timer
    import seq_detector_param_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [HOLD_W-1:0] load_val_i,
    output logic              zero_o
);

    logic [HOLD_W-1:0] cnt_q;
    logic [HOLD_W-1:0] cnt_d;

    // Next count: load wins, otherwise decrement until zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != {HOLD_W{1'b0}}) begin
            cnt_d = cnt_q - HOLD_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= {HOLD_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Zero flag straight from the register.
    always_comb begin
        zero_o = (cnt_q == {HOLD_W{1'b0}});
    end

endmodule

// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
// Parametrised serial pattern recogniser. Samples `in` on cycles where `valid`
// is high and compares the last LEN bits with PATTERN (PATTERN[LEN-1] is the
// oldest bit). On a match: `match` pulses for one clock, `hits` increments
// (saturating) and `out` is held high for HOLD clocks, retriggerable.
// Ports:
//   clock   in   1      system clock, posedge
//   _reset  in   1      synchronous reset, active low; wins over everything
//   in      in   1      serial data bit
//   valid   in   1      qualifies `in`
//   out     out  1      stretched detection flag (registered)
//   match   out  1      one-clock pulse per match (registered)
//   hits    out  CNT_W  saturating match count since reset (registered)
// -----------------------------------------------------------------------------
module seq_detector_param
    import seq_detector_param_pkg::*;
#(
    parameter int             LEN     = 3,
    parameter logic [LEN-1:0] PATTERN = 3'b011,
    parameter int             HOLD    = 4,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CNT_W   = 8
) (
    input  logic             clock,
    input  logic             _reset,
    input  logic             in,
    input  logic             valid,
    output logic             out,
    output logic             match,
    output logic [CNT_W-1:0] hits
);

    localparam int                 FILL_W   = $clog2(LEN + 1);
    localparam logic [FILL_W-1:0]  FILL_MAX = FILL_W'(LEN);
    localparam logic [FILL_W-1:0]  FILL_THR = FILL_W'(LEN - 1);
    localparam logic [CNT_W-1:0]   HITS_MAX = {CNT_W{1'b1}};

    if ((LEN < 2) || (LEN > 16) || (HOLD < 1) || (HOLD > 255)) begin : g_bad_params
        $fatal(1, "seq_detector_param: illegal LEN or HOLD parameter");
    end

    // Only LEN-1 bits of history are stored: the oldest bit of the LEN-bit
    // window is always the incoming bit's predecessor chain, and the bit that
    // would fall off next is never compared again.
    logic [LEN-2:0]     hist_q;
    logic [LEN-2:0]     hist_d;
    logic [FILL_W-1:0]  fill_q;
    logic [FILL_W-1:0]  fill_d;
    logic [LEN-1:0]     window_s;
    logic               hit_s;
    logic               match_q;
    logic [CNT_W-1:0]   hits_q;
    logic [CNT_W-1:0]   hits_d;
    state_e             state_q;
    state_e             state_d;
    logic               timer_zero_s;

    // Comparator: window as it will look after this edge's shift.
    always_comb begin
        window_s = {hist_q, in};
        if (valid && (fill_q >= FILL_THR) && (window_s == PATTERN)) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
    end

    // Next history, fill level and hit count.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        hits_d = hits_q;
        if (valid) begin
            hist_d = window_s[LEN-2:0];
        end else begin
            hist_d = hist_q;
        end
        // Non-overlapping mode forgets the fill level so LEN fresh bits are needed.
        if (hit_s && !OVERLAP) begin
            fill_d = {FILL_W{1'b0}};
        end else if (valid && (fill_q != FILL_MAX)) begin
            fill_d = fill_q + FILL_W'(1);
        end else begin
            fill_d = fill_q;
        end
        if (hit_s && (hits_q != HITS_MAX)) begin
            hits_d = hits_q + CNT_W'(1);
        end else begin
            hits_d = hits_q;
        end
    end

    // Datapath registers: history, fill, match pulse, hit counter.
    always_ff @(posedge clock) begin
        if (!_reset) begin
            hist_q  <= {(LEN-1){1'b0}};
            fill_q  <= {FILL_W{1'b0}};
            match_q <= 1'b0;
            hits_q  <= {CNT_W{1'b0}};
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= hit_s;
            hits_q  <= hits_d;
        end
    end

    // Hold window timer, reloaded on every match (retrigger).
    seq_detector_param_hold_timer u_hold_timer (
        .clk_i      (clock),
        .rst_ni     (_reset),
        .load_i     (hit_s),
        .load_val_i (hold_reload(HOLD)),
        .zero_o     (timer_zero_s)
    );

    // FSM state register.
    always_ff @(posedge clock) begin
        if (!_reset) begin
            state_q <= ST_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a match always (re)enters STRETCH; leave when timer is spent.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HUNT: begin
                if (hit_s) begin
                    state_d = ST_STRETCH;
                end else begin
                    state_d = ST_HUNT;
                end
            end
            ST_STRETCH: begin
                if (hit_s) begin
                    state_d = ST_STRETCH;
                end else if (timer_zero_s) begin
                    state_d = ST_HUNT;
                end else begin
                    state_d = ST_STRETCH;
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase
    end

    // FSM outputs; all come directly from registers.
    always_comb begin
        out   = (state_q == ST_STRETCH);
        match = match_q;
        hits  = hits_q;
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detector_param
// Self-checking bench for seq_detector_param. Four instances with different
// parameter sets share one stimulus bus; each step pushes the expected
// out/match/hits of the instance under test to a scoreboard queue, which is
// popped and compared after the clock edge.
//   u0: defaults (LEN=3, 011, HOLD=4, OVERLAP=1, CNT_W=8)
//   u1: LEN=4, 0101, OVERLAP=1
//   u2: LEN=4, 0101, OVERLAP=0
//   u3: LEN=3, 011, OVERLAP=0, CNT_W=2
// -----------------------------------------------------------------------------
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       din;
    logic       vld;

    logic       out0, match0;
    logic [7:0] hits0;
    logic       out1, match1;
    logic [7:0] hits1;
    logic       out2, match2;
    logic [7:0] hits2;
    logic       out3, match3;
    logic [1:0] hits3;

    typedef struct {
        int         dut;
        logic       eo;
        logic       em;
        logic [7:0] eh;
        string      tag;
    } exp_t;

    exp_t sb_q[$];
    int   err_cnt = 0;
    int   chk_cnt = 0;

    always #5 clk = ~clk;

    seq_detector_param u0 (
        .clock(clk), ._reset(rst_n), .in(din), .valid(vld),
        .out(out0), .match(match0), .hits(hits0)
    );

    seq_detector_param #(.LEN(4), .PATTERN(4'b0101), .OVERLAP(1'b1)) u1 (
        .clock(clk), ._reset(rst_n), .in(din), .valid(vld),
        .out(out1), .match(match1), .hits(hits1)
    );

    seq_detector_param #(.LEN(4), .PATTERN(4'b0101), .OVERLAP(1'b0)) u2 (
        .clock(clk), ._reset(rst_n), .in(din), .valid(vld),
        .out(out2), .match(match2), .hits(hits2)
    );

    seq_detector_param #(.OVERLAP(1'b0), .CNT_W(2)) u3 (
        .clock(clk), ._reset(rst_n), .in(din), .valid(vld),
        .out(out3), .match(match3), .hits(hits3)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one clock of stimulus, queue the expectation, compare after the edge.
    task automatic step(input logic r, input logic d, input logic v, input int dut,
                        input logic eo, input logic em, input logic [7:0] eh,
                        input string tag);
        exp_t       e;
        logic       o_s;
        logic       m_s;
        logic [7:0] h_s;
        rst_n = r;
        din   = d;
        vld   = v;
        e.dut = dut;
        e.eo  = eo;
        e.em  = em;
        e.eh  = eh;
        e.tag = tag;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        case (e.dut)
            0:       begin o_s = out0; m_s = match0; h_s = hits0; end
            1:       begin o_s = out1; m_s = match1; h_s = hits1; end
            2:       begin o_s = out2; m_s = match2; h_s = hits2; end
            default: begin o_s = out3; m_s = match3; h_s = {6'd0, hits3}; end
        endcase
        check_value({e.tag, ".out"},   {31'd0, o_s}, {31'd0, e.eo});
        check_value({e.tag, ".match"}, {31'd0, m_s}, {31'd0, e.em});
        check_value({e.tag, ".hits"},  {24'd0, h_s}, {24'd0, e.eh});
    endtask

    task automatic do_reset(input int dut);
        step(1'b0, 1'b1, 1'b1, dut, 1'b0, 1'b0, 8'd0, "rst");
    endtask

    initial begin
        // 1: reset with toggling data/valid, every instance cleared
        step(1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 8'd0, "t1_u0");
        step(1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 8'd0, "t1_u1");
        step(1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b0, 8'd0, "t1_u2");
        step(1'b0, 1'b1, 1'b1, 3, 1'b0, 1'b0, 8'd0, "t1_u3");

        // 2: single match on 0,1,1; out high edges 3..6
        step(1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0, 8'd0, "t2_e1");
        step(1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0, 8'd0, "t2_e2");
        step(1'b1, 1'b1, 1'b1, 0, 1'b1, 1'b1, 8'd1, "t2_e3");
        for (int i = 4; i <= 7; i++) begin
            step(1'b1, 1'b0, 1'b1, 0, (i <= 6), 1'b0, 8'd1, $sformatf("t2_e%0d", i));
        end

        // 3: retrigger on 0,1,1,0,1,1; out high edges 3..9
        do_reset(0);
        step(1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0, 8'd0, "t3_e1");
        step(1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0, 8'd0, "t3_e2");
        step(1'b1, 1'b1, 1'b1, 0, 1'b1, 1'b1, 8'd1, "t3_e3");
        step(1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0, 8'd1, "t3_e4");
        step(1'b1, 1'b1, 1'b1, 0, 1'b1, 1'b0, 8'd1, "t3_e5");
        step(1'b1, 1'b1, 1'b1, 0, 1'b1, 1'b1, 8'd2, "t3_e6");
        for (int i = 7; i <= 10; i++) begin
            step(1'b1, 1'b0, 1'b1, 0, (i <= 9), 1'b0, 8'd2, $sformatf("t3_e%0d", i));
        end

        // 4a: LEN=4 0101 overlapping -> matches at edges 4 and 6
        do_reset(1);
        step(1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b0, 8'd0, "t4a_e1");
        step(1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b0, 8'd0, "t4a_e2");
        step(1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b0, 8'd0, "t4a_e3");
        step(1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b1, 8'd1, "t4a_e4");
        step(1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b0, 8'd1, "t4a_e5");
        step(1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b1, 8'd2, "t4a_e6");
        for (int i = 7; i <= 10; i++) begin
            step(1'b1, 1'b0, 1'b1, 1, (i <= 9), 1'b0, 8'd2, $sformatf("t4a_e%0d", i));
        end

        // 4b: same stream, non-overlapping -> match at edge 4 only
        do_reset(2);
        step(1'b1, 1'b0, 1'b1, 2, 1'b0, 1'b0, 8'd0, "t4b_e1");
        step(1'b1, 1'b1, 1'b1, 2, 1'b0, 1'b0, 8'd0, "t4b_e2");
        step(1'b1, 1'b0, 1'b1, 2, 1'b0, 1'b0, 8'd0, "t4b_e3");
        step(1'b1, 1'b1, 1'b1, 2, 1'b1, 1'b1, 8'd1, "t4b_e4");
        step(1'b1, 1'b0, 1'b1, 2, 1'b1, 1'b0, 8'd1, "t4b_e5");
        step(1'b1, 1'b1, 1'b1, 2, 1'b1, 1'b0, 8'd1, "t4b_e6");
        step(1'b1, 1'b0, 1'b1, 2, 1'b1, 1'b0, 8'd1, "t4b_e7");
        step(1'b1, 1'b0, 1'b1, 2, 1'b0, 1'b0, 8'd1, "t4b_e8");

        // 5: valid gaps do not shift history; hold timer runs with valid low
        do_reset(0);
        step(1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0, 8'd0, "t5_e1");
        for (int i = 2; i <= 4; i++) begin
            step(1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 8'd0, $sformatf("t5_e%0d", i));
        end
        step(1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0, 8'd0, "t5_e5");
        step(1'b1, 1'b1, 1'b1, 0, 1'b1, 1'b1, 8'd1, "t5_e6");
        step(1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0, 8'd1, "t5_e7");

        // 6: reset during the hold window clears everything, including fill
        do_reset(0);
        step(1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0, 8'd0, "t6_e1");
        step(1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0, 8'd0, "t6_e2");
        step(1'b1, 1'b1, 1'b1, 0, 1'b1, 1'b1, 8'd1, "t6_e3");
        step(1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0, 8'd1, "t6_e4");
        step(1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 8'd0, "t6_e5");
        step(1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0, 8'd0, "t6_e6");
        step(1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0, 8'd0, "t6_e7");

        // 7: CNT_W=2 saturates at 3 after five non-overlapping matches
        do_reset(3);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0, 1'b1, 3, (k > 0), 1'b0,
                 (k < 3) ? 8'(k) : 8'd3, $sformatf("t7_m%0d_b0", k));
            step(1'b1, 1'b1, 1'b1, 3, (k > 0), 1'b0,
                 (k < 3) ? 8'(k) : 8'd3, $sformatf("t7_m%0d_b1", k));
            step(1'b1, 1'b1, 1'b1, 3, 1'b1, 1'b1,
                 (k < 2) ? 8'(k + 1) : 8'd3, $sformatf("t7_m%0d_b2", k));
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
